blake2s_round_sched: RTL and testbench
======================================

Name: blake2s_round_sched

Overview:
- Sequences the BLAKE2s compression datapath for one 64-byte message block: init, ten rounds of eight G functions, then finalization.
- Each G is issued as two half-steps. Each step carries:
  - round, G index and half
  - working-vector indices a/b/c/d
  - message-word index taken from the BLAKE2s sigma permutation
- Sits between the I/O interface / block-loading logic and the compression datapath; one instance per hash core.

Parameters:
- ROUNDS, 10, number of rounds per block. Sigma row used is round mod 10.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- start_v_i  input  1  message block loaded; request compression
- block_last_i  input  1  block is final; sampled with an accepted start_v_i
- stall_i  input  1  datapath cannot accept a step this cycle
- ready_o  output  1  idle; start_v_i will be accepted
- init_o  output  1  one-cycle pulse: load v[0..15] from h, IV, t, f
- step_v_o  output  1  valid half-step on the step outputs
- round_o  output  4  current round, 0..ROUNDS-1
- g_idx_o  output  3  G index, 0..7
- half_o  output  1  0: first half (rotations 16/12); 1: second half (rotations 8/7)
- a_idx_o, b_idx_o, c_idx_o, d_idx_o  output  4 each  working-vector word indices
- m_idx_o  output  4  message word index, SIGMA[round mod 10][2*g+half]
- final_o  output  1  one-cycle pulse: h[i] ^= v[i] ^ v[i+8]
- done_o  output  1  one-cycle pulse, same cycle as final_o
- last_o  output  1  block_last_i captured at start; valid with done_o

Behaviour:
- Conditions for I/O:
  - Clock is clk. Reset is synchronous and active-high, port reset.
  - reset dominates every other input, including mid-block: the next edge forces IDLE and clears the counters and last_o.
- After reset: ready_o=1, all other outputs 0.
- FSM states: IDLE, INIT, ROUND, FINAL.
- IDLE:
  - ready_o=1.
  - start_v_i=1 -> INIT; block_last_i is captured into last_o.
  - stall_i is ignored.
- INIT:
  - init_o=1 for exactly one cycle.
  - round, g and half counters are cleared to 0.
  - Goes to ROUND unconditionally.
- ROUND:
  - step_v_o=1 every cycle.
  - A step is consumed when stall_i=0. The counters then advance in order half -> g -> round.
  - When stall_i=1, all step outputs hold their values.
  - Leaves for FINAL when the step round=ROUNDS-1, g=7, half=1 is consumed.
- FINAL:
  - final_o=1 and done_o=1 for one cycle.
  - Goes to IDLE; ready_o=1 in the next cycle.
- start_v_i outside IDLE is ignored and never queued.
- Latency with no stalls, start accepted at cycle T:
  - INIT at T+1
  - steps at T+2..T+161 (ROUNDS*16 = 160 steps)
  - FINAL/done at T+162
  - ready at T+163
  - Each stall cycle adds 1 cycle.
- Index decode, combinational from the counters:
  - g<4 (columns): a=g, b=g+4, c=g+8, d=g+12.
  - g>=4, with j=g-4 (diagonals): a=j, b=4+((j+1) mod 4), c=8+((j+2) mod 4), d=12+((j+3) mod 4).
- Sigma is the 10x16 BLAKE2s table (RFC 7693), held as a constant ROM in the block.
- Step outputs are 0 whenever step_v_o=0.
- last_o holds until the next accepted start or reset.

Optional Feature:
- Macro SCHED_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o (16 bits).
  - Counts cycles in ROUND with stall_i=1, saturating at 16'hFFFF.
  - Cleared in INIT and by reset.
  - Holds its value after done until the next INIT.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then start_v_i=1, block_last_i=0, stall_i=0:
  - init_o at T+1.
  - 160 consecutive step_v_o cycles.
  - done_o/final_o at T+162, last_o=0.
  - ready_o=1 at T+163.
- Index check during the run above:
  - round 0, g=0, half=1 -> a,b,c,d = 0,4,8,12, m_idx=1.
  - round 1, g=0, half=0 -> m_idx=14.
  - round 9, g=7, half=1 -> a,b,c,d = 3,4,9,14, m_idx=0.
  - The full 160-step sequence matches the sigma reference model.
- Stall_i=1 for 5 cycles at round 4, g=2, half=0:
  - outputs frozen throughout the stall.
  - done_o at T+167.
  - With SCHED_STALL_CNT_EN defined, stall_cnt_o=5.
- start_v_i held at 1 throughout a block with block_last_i=1:
  - only one INIT per block.
  - last_o=1 with done_o.
  - The next INIT occurs the cycle after ready_o returns.
- reset asserted at round 6:
  - next cycle: ready_o=1, step_v_o=0, last_o=0.
  - A new start then runs a full 160 steps from round 0.

Source files
------------

// File: rtl/blake2s_round_sched.sv
// BLAKE2s round scheduler: walks one 64-byte block through INIT, ROUNDS x 8 G
// functions (each issued as two half-steps), then FINAL. It drives the working
// vector indices a/b/c/d and the sigma-permuted message word index to the
// compression datapath.
// Optional build macro SCHED_STALL_CNT_EN adds stall_cnt_o, a saturating count
// of stalled ROUND cycles in the current block.
module blake2s_round_sched #(
    parameter int ROUNDS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_v_i,
    input  logic       block_last_i,
    input  logic       stall_i,
    output logic       ready_o,
    output logic       init_o,
    output logic       step_v_o,
    output logic [3:0] round_o,
    output logic [2:0] g_idx_o,
    output logic       half_o,
    output logic [3:0] a_idx_o,
    output logic [3:0] b_idx_o,
    output logic [3:0] c_idx_o,
    output logic [3:0] d_idx_o,
    output logic [3:0] m_idx_o,
    output logic       final_o,
    output logic       done_o,
    output logic       last_o
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_FINAL = 2'd3;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    // Sigma rows from RFC 7693; the leftmost nibble is position 0 of the row.
    // A constant table built from a function, so it needs no reset.
    function automatic logic [63:0] sigma_row(input logic [3:0] row);
        case (row)
            4'd0:    sigma_row = 64'h0123456789ABCDEF;
            4'd1:    sigma_row = 64'hEA489FD61C02B753;
            4'd2:    sigma_row = 64'hB8C052FDAE367194;
            4'd3:    sigma_row = 64'h7931DCBE265A40F8;
            4'd4:    sigma_row = 64'h905724AFE1BC683D;
            4'd5:    sigma_row = 64'h2C6A0B834D75FE19;
            4'd6:    sigma_row = 64'hC51FED4A0763928B;
            4'd7:    sigma_row = 64'hDB7EC13950F4862A;
            4'd8:    sigma_row = 64'h6FE9B308C2D714A5;
            4'd9:    sigma_row = 64'hA2847615FB9E3CD0;
            default: sigma_row = 64'h0123456789ABCDEF;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  round_q, round_d;
    logic [2:0]  g_q, g_d;
    logic        half_q, half_d;
    logic        last_q, last_d;

    logic        step_v;
    logic [3:0]  a_raw, b_raw, c_raw, d_raw, m_raw;
    logic [3:0]  sig_row;
    logic [63:0] sig_word;
    logic [5:0]  sig_lo;
    logic [1:0]  j;

    // Next-state and counter advance: half -> g -> round, frozen while stalled.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        round_d = round_q;
        g_d     = g_q;
        half_d  = half_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (start_v_i) begin
                    state_d = S_INIT;
                    last_d  = block_last_i;
                end
            end
            S_INIT: begin
                round_d = 4'd0;
                g_d     = 3'd0;
                half_d  = 1'b0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (!stall_i) begin
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (g_q != 3'd7) begin
                            g_d = g_q + 3'd1;
                        end else begin
                            g_d = 3'd0;
                            if (round_q == LAST_ROUND) begin
                                state_d = S_FINAL;
                            end else begin
                                round_d = round_q + 4'd1;
                            end
                        end
                    end
                end
            end
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers; reset wins over everything, even mid-block.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            round_q <= 4'd0;
            g_q     <= 3'd0;
            half_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            g_q     <= g_d;
            half_q  <= half_d;
            last_q  <= last_d;
        end
    end

    // Index decode: columns for g<4, diagonals for g>=4 (2-bit wrap is mod 4).
    always_comb begin
        j     = g_q[1:0];
        a_raw = {2'b00, j};
        if (!g_q[2]) begin
            b_raw = {2'b01, j};
            c_raw = {2'b10, j};
            d_raw = {2'b11, j};
        end else begin
            b_raw = {2'b01, j + 2'd1};
            c_raw = {2'b10, j + 2'd2};
            d_raw = {2'b11, j + 2'd3};
        end
    end

    // Message word lookup: row is round mod 10, column is 2*g+half.
    always_comb begin
        sig_row  = (round_q >= 4'd10) ? (round_q - 4'd10) : round_q;
        sig_word = sigma_row(sig_row);
        sig_lo   = {4'd15 - {g_q, half_q}, 2'b00};
        m_raw    = sig_word[sig_lo +: 4];
    end

    assign step_v   = (state_q == S_ROUND);
    assign ready_o  = (state_q == S_IDLE);
    assign init_o   = (state_q == S_INIT);
    assign final_o  = (state_q == S_FINAL);
    assign done_o   = (state_q == S_FINAL);
    assign last_o   = last_q;
    assign step_v_o = step_v;
    assign round_o  = step_v ? round_q : 4'd0;
    assign g_idx_o  = step_v ? g_q     : 3'd0;
    assign half_o   = step_v & half_q;
    assign a_idx_o  = step_v ? a_raw   : 4'd0;
    assign b_idx_o  = step_v ? b_raw   : 4'd0;
    assign c_idx_o  = step_v ? c_raw   : 4'd0;
    assign d_idx_o  = step_v ? d_raw   : 4'd0;
    assign m_idx_o  = step_v ? m_raw   : 4'd0;

`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: cleared at INIT, saturating count of stalled ROUND cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_INIT) begin
            stall_cnt_d = 16'd0;
        end else if (step_v && stall_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register; holds after done until the next INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_blake2s_round_sched.sv
// Scoreboard bench for blake2s_round_sched. Stimulus pushes the expected event
// stream (INIT, 160 steps from the sigma reference, FINAL, timed idle checks);
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_blake2s_round_sched;

    localparam int K_INIT  = 0;
    localparam int K_STEP  = 1;
    localparam int K_FINAL = 2;
    localparam int K_RST   = 3;
    localparam int K_RDY   = 4;

    typedef struct {
        int kind;
        int cyc;
        int rnd;
        int g;
        int half;
        int a;
        int b;
        int c;
        int d;
        int m;
        int last;
        int nst;
    } ev_t;

    // BLAKE2s message schedule, RFC 7693.
    int sigma [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    // G argument quadruples: four columns then four diagonals.
    int gidx [8][4] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_v_i = 1'b0;
    logic       block_last_i = 1'b0;
    logic       stall_i = 1'b0;
    logic       ready_o, init_o, step_v_o, half_o, final_o, done_o, last_o;
    logic [3:0] round_o, a_idx_o, b_idx_o, c_idx_o, d_idx_o, m_idx_o;
    logic [2:0] g_idx_o;
`ifdef SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    blake2s_round_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start_v_i    (start_v_i),
        .block_last_i (block_last_i),
        .stall_i      (stall_i),
        .ready_o      (ready_o),
        .init_o       (init_o),
        .step_v_o     (step_v_o),
        .round_o      (round_o),
        .g_idx_o      (g_idx_o),
        .half_o       (half_o),
        .a_idx_o      (a_idx_o),
        .b_idx_o      (b_idx_o),
        .c_idx_o      (c_idx_o),
        .d_idx_o      (d_idx_o),
        .m_idx_o      (m_idx_o),
        .final_o      (final_o),
        .done_o       (done_o),
        .last_o       (last_o)
`ifdef SCHED_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    ev_t  sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int c, input int last, input int nst);
        ev_t e;
        e      = '{default: 0};
        e.kind = kind;
        e.cyc  = c;
        e.last = last;
        e.nst  = nst;
        sb.push_back(e);
    endtask

    // Issue a start in an IDLE cycle and queue INIT plus all 160 expected steps.
    task automatic start_block(input bit last, input bit keep, output int t0);
        ev_t e;
        t0           = cyc;
        start_v_i    = 1'b1;
        block_last_i = last;
        stall_i      = 1'($urandom_range(0, 1));
        push_ev(K_INIT, t0 + 1, 0, 0);
        for (int r = 0; r < 10; r++) begin
            for (int g = 0; g < 8; g++) begin
                for (int h = 0; h < 2; h++) begin
                    e      = '{default: 0};
                    e.kind = K_STEP;
                    e.cyc  = -1;
                    e.rnd  = r;
                    e.g    = g;
                    e.half = h;
                    e.a    = gidx[g][0];
                    e.b    = gidx[g][1];
                    e.c    = gidx[g][2];
                    e.d    = gidx[g][3];
                    e.m    = sigma[r % 10][2 * g + h];
                    sb.push_back(e);
                end
            end
        end
        tick();
        start_v_i    = keep ? 1'b1 : 1'($urandom_range(0, 1));
        block_last_i = 1'($urandom_range(0, 1));
        stall_i      = 1'($urandom_range(0, 1));
        tick();
    endtask

    // Drive ROUND cycles until 160 steps are consumed (or reset at abort_at).
    task automatic run_steps(input int t0, input bit last, input bit keep, input int pct,
                             input int fix_at, input int fix_len, input int abort_at);
        int consumed;
        int nst;
        int fs;
        bit s;
        consumed = 0;
        nst      = 0;
        fs       = 0;
        while (consumed < 160) begin
            if (consumed == abort_at) begin
                reset     = 1'b1;
                stall_i   = 1'b0;
                start_v_i = 1'b0;
                tick();
                reset = 1'b0;
                sb.delete();
                push_ev(K_RST, cyc, 0, 0);
                return;
            end
            if (consumed == fix_at && fs < fix_len) begin
                s = 1'b1;
                fs++;
            end else begin
                s = ($urandom_range(0, 99) < pct);
            end
            stall_i = s;
            if (!keep) start_v_i = 1'($urandom_range(0, 1));
            if (s) nst++;
            else consumed++;
            tick();
        end
        push_ev(K_FINAL, t0 + 162 + nst, last, nst);
        push_ev(K_RDY, t0 + 163 + nst, 0, 0);
        stall_i = 1'($urandom_range(0, 1));
        if (!keep) start_v_i = 1'($urandom_range(0, 1));
        tick();
        if (!keep) start_v_i = 1'b0;
        stall_i = 1'($urandom_range(0, 1));
    endtask

    task automatic pop_kind(input int k, input string nm, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        if (sb.size() == 0) begin
            check({nm, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({nm, "_kind"}, e.kind, k);
            ok = (e.kind == k);
        end
    endtask

    ev_t         me;
    bit          mok;
    bit          prev_stall = 1'b0;
    logic [27:0] prev_vec = '0;
    logic [27:0] cur_vec;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            cur_vec = {round_o, g_idx_o, half_o, a_idx_o, b_idx_o, c_idx_o, d_idx_o, m_idx_o};
            if (sb.size() > 0 && (sb[0].kind == K_RST || sb[0].kind == K_RDY) && sb[0].cyc <= cyc) begin
                me = sb.pop_front();
                check("timed_cycle", cyc, me.cyc);
                if (me.kind == K_RST) begin
                    check("rst_ready", ready_o, 1'b1);
                    check("rst_outs", {init_o, step_v_o, final_o, done_o, last_o}, 5'b0);
                end else begin
                    check("ready_after_done", ready_o, 1'b1);
                end
            end
            if (init_o) begin
                pop_kind(K_INIT, "init", me, mok);
                if (mok) check("init_cycle", cyc, me.cyc);
                check("init_not_ready", ready_o, 1'b0);
            end
            if (step_v_o) begin
                if (prev_stall) check("stall_freeze", cur_vec, prev_vec);
                if (!stall_i) begin
                    pop_kind(K_STEP, "step", me, mok);
                    if (mok) begin
                        check("step_round", round_o, me.rnd);
                        check("step_g_half", {g_idx_o, half_o}, {me.g[2:0], me.half[0]});
                        check("step_abcd", {a_idx_o, b_idx_o, c_idx_o, d_idx_o},
                              {me.a[3:0], me.b[3:0], me.c[3:0], me.d[3:0]});
                        check("step_m_idx", m_idx_o, me.m);
                    end
                end
            end else begin
                check("step_outs_zero", cur_vec, 28'd0);
            end
            if (final_o) begin
                pop_kind(K_FINAL, "final", me, mok);
                if (mok) begin
                    check("done_cycle", cyc, me.cyc);
                    check("done_with_final", done_o, 1'b1);
                    check("last_o", last_o, me.last);
`ifdef SCHED_STALL_CNT_EN
                    check("stall_cnt", stall_cnt_o, me.nst);
`endif
                end
            end else begin
                check("done_only_with_final", done_o, 1'b0);
            end
            prev_stall = step_v_o && stall_i;
            prev_vec   = cur_vec;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        bit lst;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        push_ev(K_RST, cyc, 0, 0);
        tick();
        tick();

        // Clean block, no stalls: checks exact latency.
        start_block(1'b0, 1'b0, t0);
        run_steps(t0, 1'b0, 1'b0, 0, -1, 0, -1);
        tick();

        // Five stall cycles at round 4, g=2, half=0 (step 68).
        start_block(1'b0, 1'b0, t0);
        run_steps(t0, 1'b0, 1'b0, 0, 68, 5, -1);

        // start_v_i held high through a final block; next block starts on ready.
        start_block(1'b1, 1'b1, t0);
        run_steps(t0, 1'b1, 1'b1, 20, -1, 0, -1);
        start_block(1'b0, 1'b0, t0);
        run_steps(t0, 1'b0, 1'b0, 20, -1, 0, -1);

        // Reset at round 6, then a full clean block.
        start_block(1'b1, 1'b0, t0);
        run_steps(t0, 1'b1, 1'b0, 10, -1, 0, 96);
        tick();
        start_block(1'b0, 1'b0, t0);
        run_steps(t0, 1'b0, 1'b0, 0, -1, 0, -1);

        // Randomized blocks.
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            lst = 1'($urandom_range(0, 1));
            start_block(lst, 1'b0, t0);
            run_steps(t0, lst, 1'b0, int'($urandom_range(0, 40)), -1, 0, -1);
        end

        repeat (3) tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
